// File: rtl/echo_pulse_meter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : echo_pulse_meter                                             |
// | Description : Measures the echo high time in clk cycles, with timeouts,    |
// |               valid/timeout strobes and a proximity flag.                  |
// |               Optional echo debounce filter: define ECHO_FILTER_EN.        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module echo_pulse_meter #(
    parameter int               CNT_W    = 20,
    parameter logic [CNT_W-1:0] RISE_TO  = 20'd1000000,
    parameter logic [CNT_W-1:0] HIGH_TO  = 20'd1000000,
    parameter logic [CNT_W-1:0] NEAR_MIN = 20'd2950,
    parameter logic [CNT_W-1:0] NEAR_MAX = 20'd14750
`ifdef ECHO_FILTER_EN
    ,parameter int              FILT_LEN = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             echo,
    output logic [CNT_W-1:0] contador2,
    output logic             valid,
    output logic             timeout,
    output logic             near,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] contador2_q, contador2_d;
    logic             wait_low_q, wait_low_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             near_q, near_d;
    logic             sync1_q, sync2_q;
    logic             echo_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= echo;
            sync2_q <= sync1_q;
        end
    end

`ifdef ECHO_FILTER_EN
    localparam int FC_W = $clog2(FILT_LEN + 1);

    logic [FC_W-1:0] filt_cnt_q, filt_cnt_d;
    logic            filt_q, filt_d;

    // Output follows the synced level only after FILT_LEN consecutive differing cycles.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (sync2_q != filt_q) begin
            if (filt_cnt_q == FC_W'(FILT_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q     <= 1'b0;
            filt_cnt_q <= '0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    assign echo_s = filt_q;
`else
    assign echo_s = sync2_q;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wait_low_d  = wait_low_q;
        contador2_d = contador2_q;
        near_d      = near_q;
        valid_d     = 1'b0;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ARMED;
                    cnt_d      = '0;
                    wait_low_d = echo_s;
                end
            end
            ARMED: begin
                // wait_low blocks an echo already high at arm time from counting as a rise
                if (cnt_q == RISE_TO) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else if (echo_s && !wait_low_q) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (!echo_s) begin
                        wait_low_d = 1'b0;
                    end
                end
            end
            MEASURE: begin
                if (!echo_s) begin
                    contador2_d = cnt_q;
                    near_d      = (cnt_q > NEAR_MIN) && (cnt_q < NEAR_MAX);
                    valid_d     = 1'b1;
                    state_d     = IDLE;
                end else if (cnt_q == HIGH_TO) begin
                    contador2_d = HIGH_TO;
                    near_d      = 1'b0;
                    timeout_d   = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wait_low_q  <= 1'b0;
            contador2_q <= '0;
            near_q      <= 1'b0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wait_low_q  <= wait_low_d;
            contador2_q <= contador2_d;
            near_q      <= near_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign contador2 = contador2_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign near      = near_q;
    assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_echo_pulse_meter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_echo_pulse_meter                                          |
// | Description : Self-checking bench for echo_pulse_meter (scaled timeouts).  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_echo_pulse_meter;

    localparam int C_RISE = 3000;
    localparam int C_HIGH = 4000;
    localparam int C_NMIN = 295;
    localparam int C_NMAX = 1475;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        echo;
    logic [19:0] contador2;
    logic        valid;
    logic        timeout;
    logic        near;
    logic        busy;

    int checks = 0;
    int passes = 0;
    int n_valid = 0;
    int n_to = 0;

    always #10 clk = ~clk;

    echo_pulse_meter #(
        .CNT_W    (20),
        .RISE_TO  (20'(C_RISE)),
        .HIGH_TO  (20'(C_HIGH)),
        .NEAR_MIN (20'(C_NMIN)),
        .NEAR_MAX (20'(C_NMAX))
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .echo      (echo),
        .contador2 (contador2),
        .valid     (valid),
        .timeout   (timeout),
        .near      (near),
        .busy      (busy)
    );

    always @(posedge clk) begin
        #1;
        if (valid === 1'b1) n_valid++;
        if (timeout === 1'b1) n_to++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: a pulse longer than HIGH_TO aborts; otherwise its width is reported.
    function automatic void model(input int w, output bit ev, output int ec, output bit en);
        if (w > C_HIGH) begin
            ev = 1'b0; ec = C_HIGH; en = 1'b0;
        end else begin
            ev = 1'b1; ec = w; en = (w > C_NMIN) && (w < C_NMAX);
        end
    endfunction

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_strobe(input int v0, input int t0);
        for (int i = 0; i < 200; i++) begin
            if (n_valid != v0 || n_to != t0) break;
            @(negedge clk);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic measure(input string tag, input int w, input bit ev, input int ec, input bit en);
        int v0, t0;
        v0 = n_valid;
        t0 = n_to;
        pulse_start();
        repeat ($urandom_range(0, 4)) @(negedge clk);
        echo = 1'b1;
        repeat (w) @(negedge clk);
        echo = 1'b0;
        wait_strobe(v0, t0);
        check({tag, " valid count"}, n_valid - v0, ev ? 1 : 0);
        check({tag, " timeout count"}, n_to - t0, ev ? 0 : 1);
        check({tag, " contador2"}, contador2, ec);
        check({tag, " near"}, near, en);
        check({tag, " busy"}, busy, 0);
    endtask

    typedef struct {
        int width;
        int exp_cnt;
        bit exp_near;
        bit exp_valid;
    } vec_t;

    initial begin
        vec_t tbl[9];
        int   v0, t0, elapsed, prev_cnt, w, ec;
        bit   ev, en;

        tbl[0] = '{1400, 1400, 1'b1, 1'b1};
        tbl[1] = '{2000, 2000, 1'b0, 1'b1};
        tbl[2] = '{295, 295, 1'b0, 1'b1};
        tbl[3] = '{296, 296, 1'b1, 1'b1};
        tbl[4] = '{1475, 1475, 1'b0, 1'b1};
        tbl[5] = '{1474, 1474, 1'b1, 1'b1};
        tbl[6] = '{6, 6, 1'b0, 1'b1};
        tbl[7] = '{4000, 4000, 1'b0, 1'b1};
        tbl[8] = '{4001, 4000, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; echo = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset contador2", contador2, 0);
        check("reset valid", valid, 0);
        check("reset timeout", timeout, 0);
        check("reset near", near, 0);
        check("reset busy", busy, 0);

        foreach (tbl[i])
            measure($sformatf("vec%0d", i), tbl[i].width, tbl[i].exp_valid, tbl[i].exp_cnt, tbl[i].exp_near);

`ifndef ECHO_FILTER_EN
        measure("one-cycle", 1, 1'b1, 1, 1'b0);
`endif

        // No echo at all: abort after the arming window, result untouched
        measure("pre", 1400, 1'b1, 1400, 1'b1);
        prev_cnt = contador2;
        v0 = n_valid; t0 = n_to; elapsed = 0;
        pulse_start();
        for (int i = 0; i < C_RISE + 50; i++) begin
            @(negedge clk);
            elapsed++;
            if (n_to != t0) break;
        end
        check("armed timeout window", (elapsed >= C_RISE && elapsed <= C_RISE + 3) ? 1 : 0, 1);
        repeat (4) @(negedge clk);
        check("armed timeout count", n_to - t0, 1);
        check("armed timeout no valid", n_valid - v0, 0);
        check("armed timeout contador2", contador2, prev_cnt);
        check("armed timeout near", near, 1);
        check("armed timeout busy", busy, 0);

        // Echo stuck high, with a start issued while busy
        v0 = n_valid; t0 = n_to;
        pulse_start();
        echo = 1'b1;
        for (int i = 0; i < C_HIGH + 100; i++) begin
            start = (i == 100);
            @(negedge clk);
            if (n_to != t0) break;
        end
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("stuck high timeout count", n_to - t0, 1);
        check("stuck high no valid", n_valid - v0, 0);
        check("stuck high contador2", contador2, C_HIGH);
        check("stuck high near", near, 0);
        check("stuck high busy", busy, 0);
        echo = 1'b0;
        repeat (10) @(negedge clk);

        // Echo already high at arm time must not be measured
        v0 = n_valid; t0 = n_to;
        echo = 1'b1;
        repeat (6) @(negedge clk);
        pulse_start();
        repeat (30) @(negedge clk);
        check("high-at-start busy", busy, 1);
        check("high-at-start no strobe", (n_valid - v0) + (n_to - t0), 0);
        echo = 1'b0;
        repeat (10) @(negedge clk);
        echo = 1'b1;
        repeat (50) @(negedge clk);
        echo = 1'b0;
        wait_strobe(v0, t0);
        check("high-at-start valid", n_valid - v0, 1);
        check("high-at-start contador2", contador2, 50);

        // Reset in the middle of a measurement
        v0 = n_valid; t0 = n_to;
        pulse_start();
        echo = 1'b1;
        repeat (500) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid-rst contador2", contador2, 0);
        check("mid-rst near", near, 0);
        check("mid-rst busy", busy, 0);
        rst = 1'b0;
        echo = 1'b0;
        repeat (10) @(negedge clk);
        check("mid-rst no strobe", (n_valid - v0) + (n_to - t0), 0);
        measure("post-rst", 1400, 1'b1, 1400, 1'b1);

`ifdef ECHO_FILTER_EN
        // A short glitch is swallowed by the filter, so arming continues
        v0 = n_valid; t0 = n_to;
        pulse_start();
        repeat (5) @(negedge clk);
        echo = 1'b1;
        repeat (2) @(negedge clk);
        echo = 1'b0;
        repeat (30) @(negedge clk);
        check("glitch still busy", busy, 1);
        check("glitch no strobe", (n_valid - v0) + (n_to - t0), 0);
        echo = 1'b1;
        repeat (100) @(negedge clk);
        echo = 1'b0;
        wait_strobe(v0, t0);
        check("glitch then pulse valid", n_valid - v0, 1);
        check("glitch then pulse contador2", contador2, 100);
`endif

        for (int r = 0; r < 30; r++) begin
            if ($urandom_range(0, 9) == 0) w = $urandom_range(C_HIGH - 2, C_HIGH + 20);
            else w = $urandom_range(4, 1700);
            model(w, ev, ec, en);
            measure($sformatf("rand%0d w=%0d", r, w), w, ev, ec, en);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
